// File: rtl/temp_seg_encoder.sv
// temp_seg_encoder: signed temperature to two-digit 7-segment encoder with sequential double-dabble
module temp_seg_encoder #(
  parameter bit LZB = 1'b1
) (
  input  logic       iCLK,
  input  logic       iReset,
  input  logic [7:0] iTemp,
  input  logic       iValid,
  output logic [6:0] oSegH,
  output logic [6:0] oSegL,
  output logic       oBusy,
  output logic       oDone,
  output logic       oOvf
);
  typedef enum logic [1:0] {IDLE, CONV, ENC} state_t;
  typedef enum logic [1:0] {POS, NEG, OVF} cls_t;
  localparam logic [6:0] MINUS = 7'h40;
  state_t      state_q, state_d;
  cls_t        cls_q, cls_in;
  logic [7:0]  sh_q, sh_d, bcd_q, bcd_d, bcd_adj, mag;
  logic [2:0]  cnt_q;
  logic [6:0]  segh_q, segl_q, segh_d, segl_d;
  logic        ovf_q, done_q, capture;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h3F;
      4'd1: seg7 = 7'h06;
      4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;
      4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;
      4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction
  // state register
  always_ff @(posedge iCLK)
    state_q <= iReset ? IDLE : state_d;
  // next state: eight CONV cycles counted by cnt_q, then one ENC cycle
  always_comb begin
    state_d = state_q == IDLE ? (iValid ? CONV : IDLE) :
              state_q == CONV ? (cnt_q == 3'd7 ? ENC : CONV) : IDLE;
  end
  // FSM-derived outputs
  always_comb begin
    oBusy = state_q != IDLE;
    capture = state_q == IDLE && iValid;
  end
  // capture classification, one double-dabble step and final segment encoding
  always_comb begin
    mag = iTemp[7] ? 8'(-iTemp) : iTemp;
    cls_in = (!iTemp[7] && iTemp <= 8'd99) ? POS : (iTemp >= 8'hF7) ? NEG : OVF;
    bcd_adj = {bcd_q[7:4] >= 4'd5 ? bcd_q[7:4] + 4'd3 : bcd_q[7:4],
               bcd_q[3:0] >= 4'd5 ? bcd_q[3:0] + 4'd3 : bcd_q[3:0]};
    {bcd_d, sh_d} = {bcd_adj, sh_q} << 1;
    segh_d = cls_q != POS ? MINUS : (LZB && bcd_q[7:4] == 4'd0) ? 7'h00 : seg7(bcd_q[7:4]);
    segl_d = cls_q == OVF ? MINUS : seg7(bcd_q[3:0]);
  end
  // datapath and output registers; outputs change only in ENC
  always_ff @(posedge iCLK) begin
    if (iReset) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      cls_q  <= POS;
      segh_q <= '0;
      segl_q <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= state_q == ENC;
      if (capture) begin
        sh_q  <= mag;
        bcd_q <= '0;
        cnt_q <= '0;
        cls_q <= cls_in;
      end
      if (state_q == CONV) begin
        sh_q  <= sh_d;
        bcd_q <= bcd_d;
        cnt_q <= cnt_q + 3'd1;
      end
      if (state_q == ENC) begin
        segh_q <= segh_d;
        segl_q <= segl_d;
        ovf_q  <= cls_q == OVF;
      end
    end
  end
  assign oSegH = segh_q;
  assign oSegL = segl_q;
  assign oOvf  = ovf_q;
  assign oDone = done_q;
endmodule

// File: tb/tb_temp_seg_encoder.sv
// tb_temp_seg_encoder: directed vector bench for both LZB settings
module tb_temp_seg_encoder;
  logic       clk = 1'b0, rst = 1'b1, vld = 1'b0;
  logic [7:0] temp = '0;
  logic [6:0] h1, l1, h0, l0;
  logic       b1, b0, d1, d0, o1, o0;
  int         nvec = 0, nfail = 0;
  typedef struct {
    logic [7:0] t;
    logic [6:0] h1;
    logic [6:0] l;
    logic [6:0] h0;
    logic       ovf;
  } vec_t;
  vec_t vt[13];
  temp_seg_encoder #(.LZB(1'b1)) dut1 (.iCLK(clk), .iReset(rst), .iTemp(temp), .iValid(vld),
    .oSegH(h1), .oSegL(l1), .oBusy(b1), .oDone(d1), .oOvf(o1));
  temp_seg_encoder #(.LZB(1'b0)) dut0 (.iCLK(clk), .iReset(rst), .iTemp(temp), .iValid(vld),
    .oSegH(h0), .oSegL(l0), .oBusy(b0), .oDone(d0), .oOvf(o0));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t v);
    int k, busy, done;
    logic hold_bad;
    logic [6:0] ph, pl;
    ph = h1;
    pl = l1;
    hold_bad = 1'b0;
    busy = 0;
    done = 0;
    @(negedge clk);
    temp = v.t;
    vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    temp = ~v.t;
    k = 0;
    while (!d1 && k < 20) begin
      busy += int'(b1);
      if (h1 !== ph || l1 !== pl) hold_bad = 1'b1;
      @(negedge clk);
      k++;
    end
    chk($sformatf("latency %0h", v.t), k, 9);
    chk($sformatf("busy %0h", v.t), busy, 9);
    chk($sformatf("hold %0h", v.t), hold_bad, 0);
    chk($sformatf("segH lzb1 %0h", v.t), h1, v.h1);
    chk($sformatf("segL lzb1 %0h", v.t), l1, v.l);
    chk($sformatf("segH lzb0 %0h", v.t), h0, v.h0);
    chk($sformatf("segL lzb0 %0h", v.t), l0, v.l);
    chk($sformatf("ovf %0h", v.t), {o1, o0}, {2{v.ovf}});
    chk($sformatf("done lzb0 %0h", v.t), d0, 1);
    @(negedge clk);
    done = int'(d1) + int'(d0);
    chk($sformatf("done width %0h", v.t), done, 0);
  endtask
  initial begin
    int dc;
    vt[0]  = '{8'd25,  7'h5B, 7'h6D, 7'h5B, 1'b0};
    vt[1]  = '{8'd7,   7'h00, 7'h07, 7'h3F, 1'b0};
    vt[2]  = '{8'd0,   7'h00, 7'h3F, 7'h3F, 1'b0};
    vt[3]  = '{8'hFB,  7'h40, 7'h6D, 7'h40, 1'b0};
    vt[4]  = '{8'd99,  7'h6F, 7'h6F, 7'h6F, 1'b0};
    vt[5]  = '{8'd100, 7'h40, 7'h40, 7'h40, 1'b1};
    vt[6]  = '{8'hF6,  7'h40, 7'h40, 7'h40, 1'b1};
    vt[7]  = '{8'h80,  7'h40, 7'h40, 7'h40, 1'b1};
    vt[8]  = '{8'd42,  7'h66, 7'h5B, 7'h66, 1'b0};
    vt[9]  = '{8'hF7,  7'h40, 7'h6F, 7'h40, 1'b0};
    vt[10] = '{8'hFF,  7'h40, 7'h06, 7'h40, 1'b0};
    vt[11] = '{8'd10,  7'h06, 7'h3F, 7'h06, 1'b0};
    vt[12] = '{8'd127, 7'h40, 7'h40, 7'h40, 1'b1};
    repeat (3) @(negedge clk);
    chk("reset outputs", {h1, l1, b1, d1, o1}, 0);
    rst = 1'b0;
    foreach (vt[i]) run(vt[i]);
    // iValid while busy (including the ENC cycle) is ignored; iTemp wiggles during CONV
    dc = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      vld = (k == 0 || k == 3 || k == 9);
      temp = k == 0 ? 8'd55 : 8'd11 + 8'(k);
      @(posedge clk);
      #1 dc += int'(d1);
    end
    vld = 1'b0;
    chk("ignore done count", dc, 1);
    chk("ignore segs", {h1, l1}, {7'h6D, 7'h6D});
    chk("ignore busy", b1, 0);
    // reset mid-conversion, asserted together with iValid
    run(vt[8]);
    dc = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      vld = (k == 0 || k == 4);
      temp = 8'd42;
      rst = (k == 4);
      @(posedge clk);
      #1 dc += int'(d1);
    end
    vld = 1'b0;
    rst = 1'b0;
    chk("abort done", dc, 0);
    chk("abort outputs", {h1, l1, b1, o1}, 0);
    run('{8'd31, 7'h4F, 7'h06, 7'h4F, 1'b0});
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/temp_seg_encoder.md
TEMP_SEG_ENCODER -- requirements
Module: temp_seg_encoder

Interface
REQ-001 SHALL have parameter: LZB, default 1, leading-zero blanking enable for the tens digit.
REQ-002 SHALL have port: iCLK  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port: iReset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: iTemp  input  8  temperature in degrees C, two's complement.
REQ-005 SHALL have port: iValid  input  1  one-cycle strobe, iTemp valid this cycle.
REQ-006 SHALL have port: oSegH  output  7  tens-digit pattern, feeds the display mux high input.
REQ-007 SHALL have port: oSegL  output  7  units-digit pattern, feeds the display mux low input.
REQ-008 SHALL have port: oBusy  output  1  conversion in progress.
REQ-009 SHALL have port: oDone  output  1  one-cycle pulse, new oSegH/oSegL valid.
REQ-010 SHALL have port: oOvf  output  1  last converted value was out of displayable range.

Function
REQ-011 Segment word SHALL be {g,f,e,d,c,b,a}, 1 = segment lit.
REQ-012 Codes SHALL be: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, minus=40, blank=00 (hex).
REQ-013 FSM SHALL have states IDLE, CONV and ENC; reset state is IDLE.
REQ-014 In IDLE with iValid=1 at edge N, the block SHALL capture iTemp, load the 8-bit magnitude into the shift register, clear the BCD register and enter CONV.
REQ-015 The block SHALL classify the captured value at capture time: 0..99 = positive, -9..-1 = negative, all other values = overflow.
REQ-016 CONV SHALL perform one double-dabble step per cycle: add 3 to each BCD nibble >=5, then shift left by one; 8 steps occur at edges N+1..N+8, then the FSM enters ENC.
REQ-017 At edge N+9, ENC SHALL register oSegH/oSegL, update oOvf, set oDone=1 for exactly one cycle and return to IDLE.
REQ-018 Total latency SHALL be 9 edges from the iValid sample to the output update, identical for every class.
REQ-019 Positive class: oSegL SHALL be the units digit; oSegH SHALL be the tens digit, except blank when LZB=1 and tens=0.
REQ-020 Negative class: oSegH SHALL be minus and oSegL SHALL be the magnitude digit.
REQ-021 Overflow class (>99, or <-9, including -128): oSegH=oSegL=minus and oOvf=1.
REQ-022 oOvf SHALL be 0 after any non-overflow conversion.
REQ-023 oBusy SHALL be 1 whenever state != IDLE.
REQ-024 iValid SHALL be ignored while state != IDLE (including the ENC cycle), with no queuing.
REQ-025 oSegH, oSegL and oOvf SHALL hold their value between conversions; intermediate CONV values SHALL never appear on the outputs.
REQ-026 iTemp is sampled only at capture; changes to iTemp during CONV SHALL not affect the result.

Reset
REQ-027 iReset=1 at any edge SHALL force: state IDLE, oSegH=00, oSegL=00, oBusy=0, oDone=0, oOvf=0, internal shift/BCD registers cleared.
REQ-028 Reset SHALL take priority over iValid in the same cycle.
REQ-029 Reset mid-conversion SHALL abort with no oDone pulse; the first iValid after reset release SHALL start a normal conversion.

Verification
REQ-030 Scenario: iTemp=25 with iValid -> 9 edges later oSegH=5B, oSegL=6D, oOvf=0, oDone high exactly 1 cycle, oBusy high for 9 cycles.
REQ-031 Scenario: iTemp=7 with LZB=1 -> oSegH=00, oSegL=07; with LZB=0 -> oSegH=3F, oSegL=07; iTemp=0 with LZB=1 -> 00/3F.
REQ-032 Scenario: iTemp=8'hFB (-5) -> oSegH=40, oSegL=6D, oOvf=0; iTemp=99 -> 6F/6F.
REQ-033 Scenario: iTemp=100, then -10, then -128 -> each gives 40/40 with oOvf=1; a following iTemp=42 -> 66/5B with oOvf=0.
REQ-034 Scenario: iValid pulses with iTemp=55 at edge N, and again at edges N+3 and N+9 -> only 55 is converted (6D/6D); a single oDone pulse occurs.
REQ-035 Scenario: outputs showing 66/5B, then iValid, then iReset asserted at edge N+4 -> outputs 00/00, oBusy=0, no oDone; a new iValid with 31 -> 4F/06 after 9 edges.
